// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, drives instruction memory,
// latches the returned word into D and resolves beq/j/jal/jr with one delay slot.
module if_id_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  PC_MUXsel,
  input  logic [31:0] RD1_D,
  input  logic [31:0] RD2_D,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        valid_D,
  output logic [31:0] fetch_cnt
);

  localparam logic [2:0] SEL_SEQ = 3'd0;
  localparam logic [2:0] SEL_BEQ = 3'd1;
  localparam logic [2:0] SEL_J   = 3'd2;
  localparam logic [2:0] SEL_JR  = 3'd3;

  logic [31:0] pc_f_q;
  logic [31:0] instr_d_q;
  logic [31:0] pc_d_q;
  logic        valid_d_q;
  logic [31:0] fetch_cnt_q;

  logic [31:0] pc_f_plus4;
  logic [31:0] pc_d_plus4;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        beq_taken;
  logic [31:0] npc;

  assign imm16      = instr_d_q[15:0];
  assign imm26      = instr_d_q[25:0];
  assign pc_f_plus4 = pc_f_q + 32'd4;
  assign pc_d_plus4 = pc_d_q + 32'd4;
  assign br_offset  = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_target  = pc_d_plus4 + br_offset;
  assign j_target   = {pc_d_plus4[31:28], imm26, 2'b00};
  assign beq_taken  = (RD1_D == RD2_D);

  // A reset bubble in D must never redirect fetch, whatever the decoder drives.
  always_comb begin
    npc = pc_f_plus4;
    if (valid_d_q) begin
      case (PC_MUXsel)
        SEL_SEQ: npc = pc_f_plus4;
        SEL_BEQ: npc = beq_taken ? br_target : pc_f_plus4;
        SEL_J:   npc = j_target;
        SEL_JR:  npc = RD1_D;
        default: npc = pc_f_plus4;
      endcase
    end
  end

  // The instruction at PC_F on a transfer edge is the delay slot and is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q      <= PC_RESET;
      instr_d_q   <= 32'h0;
      pc_d_q      <= 32'h0;
      valid_d_q   <= 1'b0;
      fetch_cnt_q <= 32'h0;
    end else if (!stall) begin
      pc_f_q      <= npc;
      instr_d_q   <= Instr_F;
      pc_d_q      <= pc_f_q;
      valid_d_q   <= 1'b1;
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign PC_F      = pc_f_q;
  assign Instr_D   = instr_d_q;
  assign PC_D      = pc_d_q;
  assign PC8_D     = pc_d_q + 32'd8;
  assign valid_D   = valid_d_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule
